i2c_slave_responder: RTL

Synchronous I2C target (responder) sitting on the far side of the `sda`/`scl` bus from the I2C master controller. It lets us exercise the master in-system and provides a reusable peripheral-side endpoint. SCL/SDA are oversampled on `core_clk`, START/STOP conditions and a 7-bit address are decoded, and the block does the following:
- write transfers: received bytes are handed to the fabric;
- read transfers: fabric-supplied bytes are shifted out.

SDA is driven open-drain through an output-enable only. The block never drives SCL and does no clock stretching.

---
 rtl/i2c_slave_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target endpoint: oversamples SCL/SDA on core_clk, decodes START/STOP and a
// 7-bit address, hands written bytes to the fabric and shifts fabric bytes out on reads.
module i2c_slave_responder #(
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [6:0]           own_address,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_req,
  output logic                 tx_underrun,
  output logic                 busy,
  output logic                 rw,
  output logic                 stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_SIZE - 1);
  localparam logic [3:0] ACK_PEND = 4'(DATA_SIZE);

  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_prev_reg, sda_prev_reg;

  always_ff @(posedge core_clk) begin
    if (rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_reg;
  assign scl_fall   = ~scl_s & scl_prev_reg;
  assign start_cond = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

  state_t               state_reg, state_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_SIZE-1:0] shift_reg, shift_next;
  logic [DATA_SIZE-1:0] rx_data_reg, rx_data_next;
  logic                 sda_oe_reg, sda_oe_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 tx_req_reg, tx_req_next;
  logic                 tx_underrun_reg, tx_underrun_next;
  logic                 busy_reg, busy_next;
  logic                 rw_reg, rw_next;
  logic                 stop_det_reg, stop_det_next;

  logic [DATA_SIZE-1:0] shift_in, load_byte;
  assign shift_in  = {shift_reg[DATA_SIZE-2:0], sda_s};
  // An underrun still clocks out a byte; all ones keeps SDA released.
  assign load_byte = tx_valid ? tx_data : '1;

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    rx_data_next     = rx_data_reg;
    sda_oe_next      = sda_oe_reg;
    busy_next        = busy_reg;
    rw_next          = rw_reg;
    rx_valid_next    = 1'b0;
    tx_req_next      = 1'b0;
    tx_underrun_next = 1'b0;
    stop_det_next    = 1'b0;

    if (!enable) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else if (stop_cond) begin
      state_next    = IDLE;
      sda_oe_next   = 1'b0;
      busy_next     = 1'b0;
      stop_det_next = 1'b1;
    end else if (start_cond) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b1;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == LAST_BIT) begin
            if (shift_reg[6:0] == own_address) begin
              state_next = ADDR_ACK;
              rw_next    = sda_s;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        // bit_cnt == ACK_PEND: waiting for the fall that opens the ACK slot.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (bit_cnt_reg == ACK_PEND) begin
            sda_oe_next  = 1'b1;
            bit_cnt_next = '0;
          end else begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = WR_DATA;
            if (state_reg == ADDR_ACK && rw_reg) begin
              state_next       = RD_DATA;
              shift_next       = load_byte;
              sda_oe_next      = ~load_byte[DATA_SIZE-1];
              tx_req_next      = tx_valid;
              tx_underrun_next = ~tx_valid;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_next  = shift_in;
            rx_valid_next = 1'b1;
            state_next    = WR_ACK;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_reg == LAST_BIT) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = RD_ACK;
          end else begin
            shift_next   = {shift_reg[DATA_SIZE-2:0], 1'b0};
            sda_oe_next  = ~shift_reg[DATA_SIZE-2];
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
        // bit_cnt == 1 records that the master ACKed and another byte is due.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_next = IGNORE;
            else       bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            state_next       = RD_DATA;
            bit_cnt_next     = '0;
            shift_next       = load_byte;
            sda_oe_next      = ~load_byte[DATA_SIZE-1];
            tx_req_next      = tx_valid;
            tx_underrun_next = ~tx_valid;
          end
        end
        IGNORE:  sda_oe_next = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      rx_data_reg     <= '0;
      sda_oe_reg      <= 1'b0;
      rx_valid_reg    <= 1'b0;
      tx_req_reg      <= 1'b0;
      tx_underrun_reg <= 1'b0;
      busy_reg        <= 1'b0;
      rw_reg          <= 1'b0;
      stop_det_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      rx_data_reg     <= rx_data_next;
      sda_oe_reg      <= sda_oe_next;
      rx_valid_reg    <= rx_valid_next;
      tx_req_reg      <= tx_req_next;
      tx_underrun_reg <= tx_underrun_next;
      busy_reg        <= busy_next;
      rw_reg          <= rw_next;
      stop_det_reg    <= stop_det_next;
    end
  end

  assign sda_oe      = sda_oe_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_req      = tx_req_reg;
  assign tx_underrun = tx_underrun_reg;
  assign busy        = busy_reg;
  assign rw          = rw_reg;
  assign stop_det    = stop_det_reg;

endmodule
